// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART byte arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Ceiling log2 that never returns less than 1 bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned grant_w(input int unsigned num_src);
    return clog2_min1(num_src);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_burst);
    return clog2_min1(max_burst + 1);
  endfunction

  function automatic int unsigned gap_w(input int unsigned gap_cycles);
    return clog2_min1(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester found scanning upward from ptr+1 with wrap.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned GRANT_W = grant_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               any_req_o
);

  int unsigned idx;

  // Scan offsets 1..NUM_SRC from the pointer; the nearest requester wins.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(ptr_i) + k) % NUM_SRC;
      if (!any_req_o && req_i[idx]) begin
        winner_o  = GRANT_W'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_byte_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART transmit byte channel.
module uart_byte_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 64,
  parameter  int unsigned GAP_CYCLES = 2,
  localparam int unsigned GRANT_W    = grant_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy,
  output logic                          trunc
);

  localparam int unsigned CNT_W = cnt_w(MAX_BURST);
  localparam int unsigned GAP_W = gap_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic [GRANT_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   eof_q, eof_d;

  logic [GRANT_W-1:0]     pick;
  logic                   any_req;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   xfer_fire;
  logic                   limit_hit;
  logic                   eof_now;

  uart_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req_i     (src_valid),
    .ptr_i     (ptr_q),
    .winner_o  (pick),
    .any_req_o (any_req)
  );

  // Select the granted source's handshake and payload.
  always_comb begin
    sel_valid = src_valid[grant_q];
    sel_last  = src_last[grant_q];
    sel_data  = src_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    xfer_fire = (state_q == XFER) && sel_valid && tx_ready;
    limit_hit = (MAX_BURST != 0) && (cnt_q == LIMIT);
    eof_now   = sel_last || limit_hit;
  end

  // State and counter registers; nRst high resets on the clock edge.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= GRANT_W'(NUM_SRC - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      eof_q   <= eof_d;
    end
  end

  // Next-state: arbitrate in IDLE, count bytes in XFER, time the inter-byte gap.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    eof_d   = eof_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          cnt_d   = '0;
          eof_d   = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (xfer_fire) begin
          cnt_d = cnt_q + 1'b1;
          eof_d = eof_now;
          if (eof_now) ptr_d = grant_q;
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else if (eof_now) begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = eof_q ? IDLE : XFER;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the granted source is wired straight through while in XFER.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    src_ready = '0;
    trunc     = 1'b0;
    busy      = (state_q != IDLE);
    if (state_q == XFER) begin
      tx_valid           = sel_valid;
      tx_data            = sel_valid ? sel_data : '0;
      src_ready[grant_q] = tx_ready;
      trunc              = xfer_fire && limit_hit && !sel_last;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_byte_arbiter.sv
// Scoreboard bench for uart_byte_arbiter: byte producers per source, a monitor
// checking every accepted byte, plus directed timing checks.
module tb_uart_byte_arbiter;

  localparam int unsigned NS    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned GW    = 2;
  localparam int unsigned DEPTH = 128;

  logic              clk = 1'b0;
  logic              nRst;
  logic [NS-1:0]     src_valid, src_last, src_ready;
  logic [NS*DW-1:0]  src_data;
  logic [DW-1:0]     tx_data;
  logic              tx_valid, tx_ready;
  logic [GW-1:0]     grant_id;
  logic              busy, trunc;

  logic [NS-1:0]     b_valid, b_last, b_ready;
  logic [NS*DW-1:0]  b_data;
  logic [DW-1:0]     b_tx_data;
  logic              b_tx_valid, b_tx_ready;
  logic [GW-1:0]     b_grant;
  logic              b_busy, b_trunc;

  always #5 clk = ~clk;

  uart_byte_arbiter dut (
    .clk(clk), .nRst(nRst), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .trunc(trunc)
  );

  uart_byte_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .MAX_BURST(3), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .nRst(nRst), .src_valid(b_valid), .src_data(b_data),
    .src_last(b_last), .src_ready(b_ready), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .grant_id(b_grant),
    .busy(b_busy), .trunc(b_trunc)
  );

  typedef struct packed {
    logic [GW-1:0] src;
    logic [DW-1:0] data;
    logic          tr;
  } exp_t;

  exp_t        sb[$];
  int          applied = 0;
  int          miscompares = 0;
  int          n_xfer = 0;

  logic [DW:0]  mem [NS][DEPTH];
  int unsigned  len [NS];
  int unsigned  idx [NS];
  logic [NS-1:0] en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int s, input logic [DW-1:0] d, input logic l);
    mem[s][len[s]] = {l, d};
    len[s]++;
  endtask

  task automatic push_exp(input int s, input logic [DW-1:0] d, input logic tr);
    exp_t e;
    e.src  = GW'(s);
    e.data = d;
    e.tr   = tr;
    sb.push_back(e);
  endtask

  task automatic drive_point();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_xfer(input int target, input int budget, input string name);
    int n = 0;
    while (n_xfer < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n_xfer < target) begin
      applied++;
      miscompares++;
      $display("FAIL %s: timeout, transfers %0d want %0d", name, n_xfer, target);
    end
    drive_point();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      applied++;
      miscompares++;
      $display("FAIL %s: timeout, %0d bytes still expected", name, sb.size());
    end
    drive_point();
  endtask

  // Byte producers: advance a source after each accepted byte.
  initial begin
    logic [NS-1:0] hs;
    for (int i = 0; i < NS; i++) idx[i] = 0;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    forever begin
      @(negedge clk);
      hs = src_valid & src_ready & {NS{~nRst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i]) idx[i]++;
        if (en[i] && idx[i] < len[i]) begin
          src_valid[i]          = 1'b1;
          src_data[i*DW +: DW]  = mem[i][idx[i]][DW-1:0];
          src_last[i]           = mem[i][idx[i]][DW];
        end else begin
          src_valid[i]          = 1'b0;
          src_data[i*DW +: DW]  = '0;
          src_last[i]           = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted byte must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!nRst && tx_valid && tx_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_byte: got 0x%0h from src %0d, want none", tx_data, grant_id);
        end else begin
          e = sb.pop_front();
          check("byte_src",   32'(grant_id),  32'(e.src));
          check("byte_data",  32'(tx_data),   32'(e.data));
          check("byte_trunc", 32'(trunc),     32'(e.tr));
          check("byte_ready", 32'(src_ready), 32'(4'b0001 << e.src));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_v [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
    int exp_g [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int exp_t [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    logic [DW-1:0] d;

    nRst       = 1'b1;
    tx_ready   = 1'b0;
    en         = '1;
    b_valid    = '0;
    b_last     = '0;
    b_data     = {8'h00, 8'h00, 8'hA5, 8'h5A};
    b_tx_ready = 1'b1;
    for (int i = 0; i < NS; i++) len[i] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid",  32'(tx_valid),  32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_grant",     32'(grant_id),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_trunc",     32'(trunc),     32'd0);
    drive_point();
    nRst = 1'b0;

    // 1: single byte, one-cycle latency, two gap cycles, back to IDLE
    tx_ready = 1'b1;
    load(0, 8'h41, 1'b1);
    push_exp(0, 8'h41, 1'b0);
    drive_point();
    @(negedge clk);
    check("t1_idle_valid", 32'(tx_valid), 32'd0);
    check("t1_idle_busy",  32'(busy),     32'd0);
    @(negedge clk);
    check("t1_latency",    32'(tx_valid), 32'd1);
    @(negedge clk);
    check("t1_gap1_valid", 32'(tx_valid), 32'd0);
    check("t1_gap1_busy",  32'(busy),     32'd1);
    @(negedge clk);
    check("t1_gap2_valid", 32'(tx_valid), 32'd0);
    check("t1_gap2_busy",  32'(busy),     32'd1);
    @(negedge clk);
    check("t1_end_busy",   32'(busy),     32'd0);
    check("t1_end_grant",  32'(grant_id), 32'd0);
    wait_drain(50, "t1_drain");

    // 2: four 3-byte frames; pointer sits at 0, so order is 1,2,3,0
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < 3; j++)
        load(s, 8'(8'h10 * (s + 1) + j), (j == 2));
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 3; j++)
        push_exp((k + 1) % NS, 8'(8'h10 * (((k + 1) % NS) + 1) + j), 1'b0);
    wait_drain(200, "t2_drain");

    // 3: source 2 overruns MAX_BURST; source 3 gets the channel before it resumes
    for (int k = 0; k < 70; k++) load(2, 8'(k), (k == 69));
    load(3, 8'hA5, 1'b1);
    for (int k = 0; k < 64; k++) push_exp(2, 8'(k), (k == 63));
    push_exp(3, 8'hA5, 1'b0);
    for (int k = 64; k < 70; k++) push_exp(2, 8'(k), 1'b0);
    wait_drain(600, "t3_drain");

    // 4: backpressure then source stall in mid-frame
    base = n_xfer;
    load(1, 8'hB0, 1'b0);
    load(1, 8'hB1, 1'b0);
    load(1, 8'hB2, 1'b0);
    load(1, 8'hB3, 1'b1);
    push_exp(1, 8'hB0, 1'b0);
    push_exp(1, 8'hB1, 1'b0);
    push_exp(1, 8'hB2, 1'b0);
    push_exp(1, 8'hB3, 1'b0);
    push_exp(3, 8'hC3, 1'b0);
    push_exp(0, 8'hC0, 1'b0);
    wait_xfer(base + 1, 50, "t4_first");
    tx_ready = 1'b0;
    load(0, 8'hC0, 1'b1);
    load(3, 8'hC3, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("t4_gap_valid", 32'(tx_valid), 32'd0);
    end
    base = n_xfer;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(tx_valid),  32'd1);
      check("t4_hold_data",  32'(tx_data),   32'hB1);
      check("t4_hold_ready", 32'(src_ready), 32'd0);
      check("t4_hold_grant", 32'(grant_id),  32'd1);
    end
    drive_point();
    en[1] = 1'b0;
    drive_point();
    tx_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_stall_valid", 32'(tx_valid),  32'd0);
      check("t4_stall_ready", 32'(src_ready), 32'b0010);
      check("t4_stall_busy",  32'(busy),      32'd1);
      check("t4_stall_grant", 32'(grant_id),  32'd1);
    end
    #1;
    check("t4_no_xfer", 32'(n_xfer), 32'(base));
    drive_point();
    en[1] = 1'b1;
    wait_drain(200, "t4_drain");

    // 5: reset in the middle byte aborts the frame and restores priority
    base = n_xfer;
    load(0, 8'hD0, 1'b0);
    load(0, 8'hD1, 1'b0);
    load(0, 8'hD2, 1'b1);
    push_exp(0, 8'hD0, 1'b0);
    wait_xfer(base + 1, 50, "t5_first");
    drive_point();
    drive_point();
    check("t5_mid_valid", 32'(tx_valid), 32'd1);
    check("t5_mid_data",  32'(tx_data),  32'hD1);
    nRst   = 1'b1;
    len[0] = idx[0];
    drive_point();
    nRst = 1'b0;
    load(1, 8'hE1, 1'b1);
    load(0, 8'hE0, 1'b1);
    push_exp(0, 8'hE0, 1'b0);
    push_exp(1, 8'hE1, 1'b0);
    @(negedge clk);
    check("t5_rst_valid", 32'(tx_valid),  32'd0);
    check("t5_rst_ready", 32'(src_ready), 32'd0);
    check("t5_rst_busy",  32'(busy),      32'd0);
    check("t5_rst_grant", 32'(grant_id),  32'd0);
    wait_drain(100, "t5_drain");

    // 6: no gap, MAX_BURST=3, two steady requesters on the second instance
    b_valid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      d = (exp_v[c] == 0) ? 8'h00 : ((exp_g[c] == 0) ? 8'h5A : 8'hA5);
      check("t6_valid", 32'(b_tx_valid), 32'(exp_v[c]));
      check("t6_busy",  32'(b_busy),     32'(exp_v[c]));
      check("t6_grant", 32'(b_grant),    32'(exp_g[c]));
      check("t6_trunc", 32'(b_trunc),    32'(exp_t[c]));
      check("t6_data",  32'(b_tx_data),  32'(d));
    end
    drive_point();
    b_valid = '0;

    for (int i = 0; i < NS; i++) check("src_consumed", 32'(idx[i]), 32'(len[i]));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
